// File: rtl/bongo_pkg.sv
// ============================================================================
// Module : bongo_pkg
// Brief  : Shared types and constants for the DK Bongos single-wire responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bongo_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_LOW    = 3'd1,
        RX_HIGH   = 3'd2,
        DECIDE    = 3'd3,
        TX_LOW    = 3'd4,
        TX_HIGH   = 3'd5,
        TX_STOP   = 3'd6,
        WAIT_HIGH = 3'd7
    } state_t;

    localparam logic [7:0]  CMD_PROBE    = 8'h00;
    localparam logic [15:0] CMD_POLL     = 16'h4003;
    localparam logic [4:0]  PROBE_PULSES = 5'd9;
    localparam logic [4:0]  POLL_PULSES  = 5'd25;

    // Bit-cell timing in microseconds: a 1 is short-low, a 0 is long-low.
    localparam int ONE_US    = 1;
    localparam int THRESH_US = 2;
    localparam int ZERO_US   = 3;
    localparam int BIT_US    = 4;

endpackage

`default_nettype wire

// File: rtl/line_sync_edge.sv
// ============================================================================
// Module : line_sync_edge
// Brief  : 2-flop synchronizer with a registered falling-edge pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module line_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;
    logic r_fall;

    // o_level is the history flop so that level and fall pulse change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_fall  <= r_hist & ~r_sync2;
        end
    end

    assign o_level = r_hist;
    assign o_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/bongo_responder.sv
// ============================================================================
// Module : bongo_responder
// Brief  : Controller-side DK Bongos responder: decodes probe/poll, answers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bongo_responder
    import bongo_pkg::*;
#(
    parameter int          CYCLES_PER_US = 50,
    parameter int          GAP_US        = 5,
    parameter int          ABORT_US      = 100,
    parameter logic [23:0] DEVICE_ID     = 24'h090000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_line_in,
    output logic        o_line_drive_low,
    input  logic [63:0] i_report,
    output logic        o_poll_strobe,
    output logic        o_rumble,
    output logic        o_busy
);

    localparam logic [12:0] c_ONE_CYC    = 13'(ONE_US    * CYCLES_PER_US);
    localparam logic [12:0] c_THRESH_CYC = 13'(THRESH_US * CYCLES_PER_US);
    localparam logic [12:0] c_ZERO_CYC   = 13'(ZERO_US   * CYCLES_PER_US);
    localparam logic [12:0] c_BIT_CYC    = 13'(BIT_US    * CYCLES_PER_US);
    localparam logic [12:0] c_GAP_CYC    = 13'(GAP_US    * CYCLES_PER_US);
    localparam logic [12:0] c_ABORT_CYC  = 13'(ABORT_US  * CYCLES_PER_US);

    logic        w_level;
    logic        w_fall;
    logic [23:0] w_frame;
    logic [12:0] w_low_len;
    logic [12:0] w_high_len;

    state_t      r_state;
    logic [12:0] r_cnt;
    logic [24:0] r_rx_shift;
    logic [4:0]  r_pulses;
    logic [63:0] r_tx;
    logic [6:0]  r_bits;
    logic        r_drive;
    logic        r_poll_strobe;
    logic        r_rumble;

    line_sync_edge u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_line  (i_line_in),
        .o_level (w_level),
        .o_fall  (w_fall)
    );

    // One extra shifter bit holds the host stop bit so the frame excludes it.
    assign w_frame    = r_rx_shift[24:1];
    assign w_low_len  = r_tx[63] ? c_ONE_CYC : c_ZERO_CYC;
    assign w_high_len = c_BIT_CYC - w_low_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_rx_shift    <= '0;
            r_pulses      <= '0;
            r_tx          <= '0;
            r_bits        <= '0;
            r_drive       <= 1'b0;
            r_poll_strobe <= 1'b0;
            r_rumble      <= 1'b0;
        end else begin
            r_poll_strobe <= 1'b0;
            r_cnt         <= r_cnt + 13'd1;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) begin
                        r_state    <= RX_LOW;
                        r_rx_shift <= '0;
                        r_pulses   <= '0;
                    end
                end
                RX_LOW: begin
                    if (w_level) begin
                        r_rx_shift <= {r_rx_shift[23:0], (r_cnt < c_THRESH_CYC)};
                        if (r_pulses != 5'd31)
                            r_pulses <= r_pulses + 5'd1;
                        r_state <= RX_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt >= c_ABORT_CYC - 13'd1) begin
                        r_state <= WAIT_HIGH;
                        r_cnt   <= '0;
                    end
                end
                RX_HIGH: begin
                    if (w_fall) begin
                        r_state <= RX_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt >= c_GAP_CYC - 13'd1) begin
                        r_state <= DECIDE;
                        r_cnt   <= '0;
                    end
                end
                DECIDE: begin
                    r_cnt <= '0;
                    if (r_pulses == PROBE_PULSES && w_frame[7:0] == CMD_PROBE) begin
                        r_tx    <= {DEVICE_ID, 40'd0};
                        r_bits  <= 7'd24;
                        r_drive <= 1'b1;
                        r_state <= TX_LOW;
                    end else if (r_pulses == POLL_PULSES && w_frame[23:8] == CMD_POLL) begin
                        r_tx          <= i_report;
                        r_bits        <= 7'd64;
                        r_rumble      <= w_frame[0];
                        r_poll_strobe <= 1'b1;
                        r_drive       <= 1'b1;
                        r_state       <= TX_LOW;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                TX_LOW: begin
                    if (r_cnt == w_low_len - 13'd1) begin
                        r_drive <= 1'b0;
                        r_state <= TX_HIGH;
                        r_cnt   <= '0;
                    end
                end
                TX_HIGH: begin
                    if (r_cnt == w_high_len - 13'd1) begin
                        r_tx    <= {r_tx[62:0], 1'b0};
                        r_bits  <= r_bits - 7'd1;
                        r_drive <= 1'b1;
                        r_state <= (r_bits == 7'd1) ? TX_STOP : TX_LOW;
                        r_cnt   <= '0;
                    end
                end
                TX_STOP: begin
                    if (r_cnt == c_ONE_CYC - 13'd1) begin
                        r_drive <= 1'b0;
                        r_state <= WAIT_HIGH;
                        r_cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    // Also swallows the synchronizer lag on our own released stop bit.
                    if (w_level) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_line_drive_low = r_drive;
    assign o_poll_strobe    = r_poll_strobe;
    assign o_rumble         = r_rumble;
    assign o_busy           = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bongo_responder.sv
// ============================================================================
// Module : tb_bongo_responder
// Brief  : Directed table-driven bench for bongo_responder (10 MHz time base).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bongo_responder;

    localparam int CPU = 10;

    typedef struct {
        logic [31:0] cmd;
        int          nbits;
        logic [63:0] rep;
        bit          mid_zero;
        int          exp_len;
        logic [63:0] exp_word;
        int          exp_strobes;
        logic        exp_rumble;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_low;
    logic [63:0] report;
    wire         w_line;
    logic        o_drive;
    logic        o_strobe;
    logic        o_rumble;
    logic        o_busy;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;
    int drive_cnt  = 0;

    vec_t vecs[8];

    assign w_line = ~(host_low | o_drive);

    always #50 clk = ~clk;

    bongo_responder #(
        .CYCLES_PER_US (CPU),
        .GAP_US        (5),
        .ABORT_US      (100),
        .DEVICE_ID     (24'h090000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_line_in        (w_line),
        .o_line_drive_low (o_drive),
        .i_report         (report),
        .o_poll_strobe    (o_strobe),
        .o_rumble         (o_rumble),
        .o_busy           (o_busy)
    );

    always @(negedge clk) begin
        if (o_strobe) strobe_cnt++;
        if (o_drive)  drive_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] v, input int n, input bit with_stop);
        for (int i = n - 1; i >= 0; i--) begin
            host_low = 1'b1;
            repeat (v[i] ? CPU : 3 * CPU) @(negedge clk);
            host_low = 1'b0;
            repeat (v[i] ? 3 * CPU : CPU) @(negedge clk);
        end
        if (with_stop) begin
            host_low = 1'b1;
            repeat (CPU) @(negedge clk);
            host_low = 1'b0;
        end
    endtask

    task automatic capture(input int nb, output logic [63:0] w, output int first_low,
                           output int stop_low, output int tot, output bit to);
        int l;
        int h;
        int t;
        w = '0; first_low = 0; stop_low = 0; tot = 0; to = 1'b0; t = 0;
        while (!o_drive && t < 40 * CPU) begin
            @(negedge clk);
            t++;
        end
        if (!o_drive) begin
            to = 1'b1;
            return;
        end
        for (int i = 0; i <= nb; i++) begin
            l = 0;
            while (o_drive && l < 10 * CPU) begin
                @(negedge clk);
                l++;
            end
            if (i == 0) first_low = l;
            tot += l;
            if (i == nb) begin
                stop_low = l;
            end else begin
                w = {w[62:0], (l < 2 * CPU)};
                h = 0;
                while (!o_drive && h < 10 * CPU) begin
                    @(negedge clk);
                    h++;
                end
                tot += h;
            end
        end
    endtask

    task automatic check_response(input string nm, input int len, input logic [63:0] exp_word);
        logic [63:0] w;
        int fl;
        int sl;
        int tt;
        bit to;
        logic [63:0] sh;
        sh = exp_word >> (len - 1);
        capture(len, w, fl, sl, tt, to);
        chk({nm, "_timeout"}, 64'(to), 64'd0);
        if (!to) begin
            chk({nm, "_word"}, w, exp_word);
            chk({nm, "_first_low"}, 64'(fl), sh[0] ? 64'(CPU) : 64'(3 * CPU));
            chk({nm, "_stop_low"}, 64'(sl), 64'(CPU));
            chk({nm, "_total"}, 64'(tt), 64'((4 * len + 1) * CPU));
        end
    endtask

    initial begin
        int s0;
        int d0;
        int t;
        vecs[0] = '{32'h00,      8,  64'h0,                  1'b0, 24, 64'h090000,             0, 1'b0};
        vecs[1] = '{32'h400301,  24, 64'h0123_4567_89AB_CDEF, 1'b0, 64, 64'h0123_4567_89AB_CDEF, 1, 1'b1};
        vecs[2] = '{32'h400300,  24, 64'hFEDC_BA98_7654_3210, 1'b1, 64, 64'hFEDC_BA98_7654_3210, 1, 1'b0};
        vecs[3] = '{32'h400301,  24, 64'hA5A5_5A5A_FFFF_0000, 1'b0, 64, 64'hA5A5_5A5A_FFFF_0000, 1, 1'b1};
        vecs[4] = '{32'h41,      8,  64'h0,                  1'b0, 0,  64'h0,                  0, 1'b1};
        vecs[5] = '{32'h000,     9,  64'h0,                  1'b0, 0,  64'h0,                  0, 1'b1};
        vecs[6] = '{32'h400401,  24, 64'h0,                  1'b0, 0,  64'h0,                  0, 1'b1};
        vecs[7] = '{32'h0800603, 25, 64'h0,                  1'b0, 0,  64'h0,                  0, 1'b1};

        rst_n = 1'b0; host_low = 1'b0; report = '0;
        repeat (5) @(negedge clk);
        chk("rst_drive",  64'(o_drive),  64'd0);
        chk("rst_busy",   64'(o_busy),   64'd0);
        chk("rst_strobe", 64'(o_strobe), 64'd0);
        chk("rst_rumble", 64'(o_rumble), 64'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            report = vecs[i].rep;
            s0 = strobe_cnt;
            d0 = drive_cnt;
            send(vecs[i].cmd, vecs[i].nbits, 1'b1);
            if (vecs[i].exp_len == 0) begin
                repeat (20 * CPU) @(negedge clk);
                chk($sformatf("v%0d_silent", i), 64'(drive_cnt - d0), 64'd0);
            end else if (vecs[i].mid_zero) begin
                fork
                    check_response($sformatf("v%0d", i), vecs[i].exp_len, vecs[i].exp_word);
                    begin
                        repeat (40 * CPU) @(negedge clk);
                        report = 64'h0;
                    end
                join
            end else begin
                check_response($sformatf("v%0d", i), vecs[i].exp_len, vecs[i].exp_word);
            end
            repeat (10 * CPU) @(negedge clk);
            chk($sformatf("v%0d_strobes", i), 64'(strobe_cnt - s0), 64'(vecs[i].exp_strobes));
            chk($sformatf("v%0d_rumble", i), 64'(o_rumble), 64'(vecs[i].exp_rumble));
            chk($sformatf("v%0d_busy", i), 64'(o_busy), 64'd0);
        end

        // Long low mid-frame aborts it; the following poll must still be answered.
        d0 = drive_cnt;
        send(32'h40, 8, 1'b0);
        host_low = 1'b1;
        repeat (120 * CPU) @(negedge clk);
        host_low = 1'b0;
        repeat (20 * CPU) @(negedge clk);
        chk("abort_silent", 64'(drive_cnt - d0), 64'd0);
        chk("abort_busy", 64'(o_busy), 64'd0);
        report = 64'h1122_3344_5566_7788;
        s0 = strobe_cnt;
        send(32'h400300, 24, 1'b1);
        check_response("after_abort", 64, 64'h1122_3344_5566_7788);
        repeat (10 * CPU) @(negedge clk);
        chk("after_abort_strobes", 64'(strobe_cnt - s0), 64'd1);
        chk("after_abort_rumble", 64'(o_rumble), 64'd0);

        // Reset lands while the line is being pulled low mid-response.
        send(32'h400301, 24, 1'b1);
        t = 0;
        while (!o_drive && t < 40 * CPU) begin
            @(negedge clk);
            t++;
        end
        repeat (40 * CPU) @(negedge clk);
        t = 0;
        while (!o_drive && t < 10 * CPU) begin
            @(negedge clk);
            t++;
        end
        chk("pre_rst_drive", 64'(o_drive), 64'd1);
        chk("pre_rst_rumble", 64'(o_rumble), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_drive", 64'(o_drive), 64'd0);
        chk("mid_rst_busy", 64'(o_busy), 64'd0);
        chk("mid_rst_rumble", 64'(o_rumble), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20 * CPU) @(negedge clk);
        send(32'h00, 8, 1'b1);
        check_response("post_rst_probe", 24, 64'h090000);
        repeat (10 * CPU) @(negedge clk);
        chk("post_rst_busy", 64'(o_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
